// File: rtl/wb_port_scheduler.sv
// wb_port_scheduler
//
// Sequences writeback results onto a register file that has only one write
// port. An accepted instruction may carry an E result (valE -> dstE) and an
// M result (valM -> dstM). When both are present, the E write goes out first.
// The M write is buffered and issued on the following cycle, and ready_o is
// held low for that extra cycle.
//
// The first non-AOK status is latched and the block then freezes. A counter
// tracks the number of retired AOK instructions.
//
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   wb_valid_i/ready_o  upstream handshake; accept = wb_valid_i & ready_o
//   stat_i              instruction status (00 AOK, 01 HLT, 10 ADR, 11 INS)
//   dstE_i/valE_i       E destination and value (RNONE = no destination)
//   dstM_i/valM_i       M destination and value (RNONE = no destination)
//   wr_en_o/wr_addr_o/wr_data_o  registered register-file write port
//   halted_o, stat_o    latched halt flag and status
//   retired_o           count of accepted AOK instructions (wraps)

module wb_port_scheduler #(
    parameter int         DATA_W = 64,
    parameter int         CNT_W  = 32,
    parameter logic [3:0] RNONE  = 4'hF
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wb_valid_i,
    output logic              ready_o,
    input  logic [1:0]        stat_i,
    input  logic [3:0]        dstE_i,
    input  logic [3:0]        dstM_i,
    input  logic [DATA_W-1:0] valE_i,
    input  logic [DATA_W-1:0] valM_i,
    output logic              wr_en_o,
    output logic [3:0]        wr_addr_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic              halted_o,
    output logic [1:0]        stat_o,
    output logic [CNT_W-1:0]  retired_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WR_E   = 2'd1,
        WR_M   = 2'd2,
        HALTED = 2'd3
    } state_t;

    localparam logic [1:0] STAT_AOK = 2'b00;

    state_t              state_q, state_d;
    logic                m_pend_q, m_pend_d;
    logic [3:0]          m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic                wr_en_q, wr_en_d;
    logic [3:0]          wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0]   wr_data_q, wr_data_d;
    logic                halted_q, halted_d;
    logic [1:0]          stat_q, stat_d;
    logic [CNT_W-1:0]    retired_q, retired_d;

    logic accept;
    logic e_present;
    logic m_present;
    logic e_effective;

    // The port is free next cycle unless a buffered M write still has to go out.
    assign ready_o = (state_q == IDLE) || (state_q == WR_M) ||
                     ((state_q == WR_E) && !m_pend_q);

    assign accept    = wb_valid_i && ready_o;
    assign e_present = (dstE_i != RNONE);
    assign m_present = (dstM_i != RNONE);
    // When both results target the same register, M wins and E is dropped
    // (popq %rsp: the loaded value must be the final register contents).
    assign e_effective = e_present && !(m_present && (dstE_i == dstM_i));

    always_comb begin
        state_d   = state_q;
        m_pend_d  = m_pend_q;
        m_addr_d  = m_addr_q;
        m_data_d  = m_data_q;
        wr_en_d   = 1'b0;
        wr_addr_d = RNONE;
        wr_data_d = wr_data_q;
        halted_d  = halted_q;
        stat_d    = stat_q;
        retired_d = retired_q;

        if (state_q == HALTED) begin
            state_d = HALTED;
        end else if ((state_q == WR_E) && m_pend_q) begin
            // Second half of a split pair: issue the buffered M write.
            state_d   = WR_M;
            m_pend_d  = 1'b0;
            wr_en_d   = 1'b1;
            wr_addr_d = m_addr_q;
            wr_data_d = m_data_q;
        end else if (accept) begin
            if (stat_i == STAT_AOK) begin
                retired_d = retired_q + CNT_W'(1);
                if (e_effective) begin
                    state_d   = WR_E;
                    wr_en_d   = 1'b1;
                    wr_addr_d = dstE_i;
                    wr_data_d = valE_i;
                    m_pend_d  = m_present;
                    m_addr_d  = dstM_i;
                    m_data_d  = valM_i;
                end else if (m_present) begin
                    state_d   = WR_M;
                    m_pend_d  = 1'b0;
                    wr_en_d   = 1'b1;
                    wr_addr_d = dstM_i;
                    wr_data_d = valM_i;
                end else begin
                    state_d  = IDLE;
                    m_pend_d = 1'b0;
                end
            end else begin
                state_d  = HALTED;
                m_pend_d = 1'b0;
                halted_d = 1'b1;
                stat_d   = stat_i;
            end
        end else begin
            state_d  = IDLE;
            m_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            m_pend_q  <= 1'b0;
            m_addr_q  <= RNONE;
            m_data_q  <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= RNONE;
            wr_data_q <= '0;
            halted_q  <= 1'b0;
            stat_q    <= STAT_AOK;
            retired_q <= '0;
        end else begin
            state_q   <= state_d;
            m_pend_q  <= m_pend_d;
            m_addr_q  <= m_addr_d;
            m_data_q  <= m_data_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            halted_q  <= halted_d;
            stat_q    <= stat_d;
            retired_q <= retired_d;
        end
    end

    assign wr_en_o   = wr_en_q;
    assign wr_addr_o = wr_addr_q;
    assign wr_data_o = wr_data_q;
    assign halted_o  = halted_q;
    assign stat_o    = stat_q;
    assign retired_o = retired_q;

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed testbench for wb_port_scheduler. Inputs change 1 time unit after
// the rising edge, and outputs are checked in that same window.

module tb_wb_port_scheduler;

    localparam int DATA_W = 64;
    localparam int CNT_W  = 32;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              wb_valid_i;
    logic              ready_o;
    logic [1:0]        stat_i;
    logic [3:0]        dstE_i;
    logic [3:0]        dstM_i;
    logic [DATA_W-1:0] valE_i;
    logic [DATA_W-1:0] valM_i;
    logic              wr_en_o;
    logic [3:0]        wr_addr_o;
    logic [DATA_W-1:0] wr_data_o;
    logic              halted_o;
    logic [1:0]        stat_o;
    logic [CNT_W-1:0]  retired_o;

    int n_compared   = 0;
    int n_mismatched = 0;

    wb_port_scheduler #(.DATA_W(DATA_W), .CNT_W(CNT_W), .RNONE(4'hF)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .wb_valid_i (wb_valid_i),
        .ready_o    (ready_o),
        .stat_i     (stat_i),
        .dstE_i     (dstE_i),
        .dstM_i     (dstM_i),
        .valE_i     (valE_i),
        .valM_i     (valM_i),
        .wr_en_o    (wr_en_o),
        .wr_addr_o  (wr_addr_o),
        .wr_data_o  (wr_data_o),
        .halted_o   (halted_o),
        .stat_o     (stat_o),
        .retired_o  (retired_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] st, input logic [3:0] de, input logic [63:0] ve,
                         input logic [3:0] dm, input logic [63:0] vm);
        wb_valid_i = v;
        stat_i     = st;
        dstE_i     = de;
        valE_i     = ve;
        dstM_i     = dm;
        valM_i     = vm;
        $display("txn: valid=%0b stat=%0d dstE=%0h valE=0x%0h dstM=%0h valM=0x%0h", v, st, de, ve, dm, vm);
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        drive(1'b0, 2'b00, 4'hF, 64'h0, 4'hF, 64'h0);
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic check_wr(input string tag, input logic en, input logic [3:0] addr, input logic [63:0] data);
        check({tag, ".wr_en"},   {63'h0, wr_en_o}, {63'h0, en});
        check({tag, ".wr_addr"}, {60'h0, wr_addr_o}, {60'h0, addr});
        check({tag, ".wr_data"}, wr_data_o, data);
    endtask

    initial begin
        rst_i = 1'b1;
        drive(1'b0, 2'b00, 4'hF, 64'h0, 4'hF, 64'h0);

        // Reset state
        do_reset();
        check_wr("rst", 1'b0, 4'hF, 64'h0);
        check("rst.halted",  {63'h0, halted_o}, 64'h0);
        check("rst.stat",    {62'h0, stat_o}, 64'h0);
        check("rst.retired", {32'h0, retired_o}, 64'h0);
        check("rst.ready",   {63'h0, ready_o}, 64'h1);

        // Single E write
        drive(1'b1, 2'b00, 4'h3, 64'h11, 4'hF, 64'h0);
        step();
        drive(1'b0, 2'b00, 4'hF, 64'h0, 4'hF, 64'h0);
        check_wr("single", 1'b1, 4'h3, 64'h11);
        check("single.retired", {32'h0, retired_o}, 64'd1);
        check("single.ready",   {63'h0, ready_o}, 64'h1);
        step();
        check_wr("idle1", 1'b0, 4'hF, 64'h11);

        // Split pair, valid held high, then a follow-on instruction accepted in WR_M
        drive(1'b1, 2'b00, 4'h4, 64'hA, 4'h7, 64'hB);
        step();
        check_wr("splitE", 1'b1, 4'h4, 64'hA);
        check("splitE.ready",   {63'h0, ready_o}, 64'h0);
        check("splitE.retired", {32'h0, retired_o}, 64'd2);
        step();
        check_wr("splitM", 1'b1, 4'h7, 64'hB);
        check("splitM.ready",   {63'h0, ready_o}, 64'h1);
        check("splitM.retired", {32'h0, retired_o}, 64'd2);
        drive(1'b1, 2'b00, 4'h5, 64'h55, 4'hF, 64'h0);
        step();
        drive(1'b0, 2'b00, 4'hF, 64'h0, 4'hF, 64'h0);
        check_wr("nobubble", 1'b1, 4'h5, 64'h55);
        check("nobubble.retired", {32'h0, retired_o}, 64'd3);
        step();
        check_wr("idle2", 1'b0, 4'hF, 64'h55);

        // Same destination: M wins, exactly one write
        drive(1'b1, 2'b00, 4'h4, 64'h1, 4'h4, 64'h2);
        step();
        drive(1'b0, 2'b00, 4'hF, 64'h0, 4'hF, 64'h0);
        check_wr("samedst", 1'b1, 4'h4, 64'h2);
        check("samedst.ready",   {63'h0, ready_o}, 64'h1);
        check("samedst.retired", {32'h0, retired_o}, 64'd4);
        step();
        check_wr("samedst.after", 1'b0, 4'hF, 64'h2);

        // nop
        drive(1'b1, 2'b00, 4'hF, 64'h99, 4'hF, 64'h98);
        step();
        drive(1'b0, 2'b00, 4'hF, 64'h0, 4'hF, 64'h0);
        check_wr("nop", 1'b0, 4'hF, 64'h2);
        check("nop.retired", {32'h0, retired_o}, 64'd5);

        // Halt after two AOK instructions
        do_reset();
        drive(1'b1, 2'b00, 4'h1, 64'h1, 4'hF, 64'h0);
        step();
        check_wr("aok1", 1'b1, 4'h1, 64'h1);
        drive(1'b1, 2'b00, 4'hF, 64'h0, 4'h2, 64'h22);
        step();
        check_wr("aok2", 1'b1, 4'h2, 64'h22);
        drive(1'b1, 2'b01, 4'h6, 64'h66, 4'hF, 64'h0);
        step();
        check_wr("hlt", 1'b0, 4'hF, 64'h22);
        check("hlt.halted",  {63'h0, halted_o}, 64'h1);
        check("hlt.stat",    {62'h0, stat_o}, 64'h1);
        check("hlt.retired", {32'h0, retired_o}, 64'd2);
        check("hlt.ready",   {63'h0, ready_o}, 64'h0);
        for (int i = 0; i < 3; i++) begin
            drive(i[0] ? 1'b0 : 1'b1, 2'b10, 4'h3, 64'h33, 4'h8, 64'h88);
            step();
            check("halted.wr_en",   {63'h0, wr_en_o}, 64'h0);
            check("halted.ready",   {63'h0, ready_o}, 64'h0);
            check("halted.stat",    {62'h0, stat_o}, 64'h1);
            check("halted.retired", {32'h0, retired_o}, 64'd2);
        end

        // Reset during WR_E of a split pair
        do_reset();
        check("unhalt.halted", {63'h0, halted_o}, 64'h0);
        drive(1'b1, 2'b00, 4'h8, 64'h80, 4'h9, 64'h90);
        step();
        check_wr("rstsplitE", 1'b1, 4'h8, 64'h80);
        rst_i = 1'b1;
        drive(1'b0, 2'b00, 4'hF, 64'h0, 4'hF, 64'h0);
        step();
        check_wr("midrst", 1'b0, 4'hF, 64'h0);
        check("midrst.retired", {32'h0, retired_o}, 64'd0);
        check("midrst.ready",   {63'h0, ready_o}, 64'h1);
        rst_i = 1'b0;
        step();
        check_wr("midrst.noM", 1'b0, 4'hF, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/wb_port_scheduler.md
Name: wb_port_scheduler

Overview:
- Sequences writeback-stage results onto the register file's single write port.
- Each accepted instruction may carry two results: valE to dstE and valM to dstM.
- When both are present, the block splits them into back-to-back port writes and stalls upstream for the extra cycle.
- Also latches the first non-AOK status, freezes architectural state on it, and counts retired instructions.

Parameters:
- DATA_W, 64, width of valE/valM and the write data.
- CNT_W, 32, width of the retired-instruction counter.
- RNONE, 4'hF, register ID meaning "no destination".

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset; synchronous, active-high.
- wb_valid_i  input  1  writeback stage presents an instruction.
- ready_o  output  1  scheduler accepts this cycle; accept = wb_valid_i & ready_o.
- stat_i  input  2  instruction status: 00 AOK, 01 HLT, 10 ADR, 11 INS.
- dstE_i  input  4  destination for valE; RNONE = none.
- dstM_i  input  4  destination for valM; RNONE = none.
- valE_i  input  DATA_W  ALU result.
- valM_i  input  DATA_W  memory result.
- wr_en_o  output  1  register-file write enable (registered).
- wr_addr_o  output  4  register-file write address (registered).
- wr_data_o  output  DATA_W  register-file write data (registered).
- halted_o  output  1  a non-AOK instruction has been accepted.
- stat_o  output  2  latched status; 00 until halted.
- retired_o  output  CNT_W  count of accepted AOK instructions.

Behaviour:
- Reset (synchronous, rst_i=1 at the clock edge):
  - state=IDLE.
  - wr_en_o=0, wr_addr_o=RNONE, wr_data_o=0.
  - halted_o=0, stat_o=00, retired_o=0, internal buffers cleared.
  - Reset overrides everything, including mid-split and HALTED.
- States:
  - IDLE: port unused this cycle.
  - WR_E: driving the E write.
  - WR_M: driving the M write.
  - HALTED: terminal.
- Outputs are registered: a write driven in state S appears on wr_* during the cycle the FSM is in S. Latency from accept to the first write is 1 cycle.
- ready_o (combinational):
  - 1 in IDLE.
  - 1 in WR_M.
  - 1 in WR_E when no M write is pending.
  - 0 in WR_E when an M write is pending.
  - 0 in HALTED.
  - Accepting in WR_E/WR_M gives back-to-back writes with no bubble.
- Accept of an AOK instruction:
  - eE = (dstE_i != RNONE), eM = (dstM_i != RNONE).
  - If eE & eM & dstE_i == dstM_i: drop E, do M only (M has priority, the popq %rsp rule).
  - eE: next = WR_E, with the M write buffered if eM.
  - Only eM: next = WR_M.
  - Neither: next = IDLE.
  - retired_o += 1, wrapping modulo 2^CNT_W.
- Accept of a non-AOK instruction:
  - No register writes.
  - next = HALTED, halted_o=1, stat_o=stat_i.
  - retired_o is unchanged.
- State transitions:
  - WR_E with M pending -> WR_M (the buffered M write).
  - WR_E or WR_M with no accept this cycle -> IDLE.
- HALTED: wr_en_o=0 and ready_o=0 until reset; inputs are ignored.
- wb_valid_i=0 or ready_o=0: no accept, and upstream holds its inputs stable. Inputs are not sampled when not accepted.
- While wr_en_o=0: wr_addr_o=RNONE, wr_data_o holds its last value.

Test Plan:
- Reset, then accept {AOK, dstE=3, valE=0x11, dstM=F} -> next cycle wr_en=1, addr=3, data=0x11; retired=1; ready stays 1.
- Accept {AOK, dstE=4, valE=0xA, dstM=7, valM=0xB} with wb_valid held high -> ready_o=0 during the WR_E cycle; writes (4,0xA) then (7,0xB) on consecutive cycles; the next instruction is accepted in the WR_M cycle with no bubble.
- Accept {AOK, dstE=4, dstM=4, valE=0x1, valM=0x2} -> exactly one write (4,0x2).
- Accept {AOK, dstE=F, dstM=F} (nop) -> no write; retired increments.
- Accept {HLT} after two AOK instructions -> halted_o=1, stat_o=01, retired=2, no write; later wb_valid pulses are ignored with ready_o=0.
- Assert rst_i during WR_E of a split pair -> next cycle all outputs are at reset values and the M write is never issued.
